mxv_lane_scheduler: RTL and testbench

//  Parametrised successor to the fixed-lane matrix-by-vector controller.

---
 rtl/mxv_pkg.sv | 15 +
 rtl/mxv_lane_mac.sv | 40 ++++
 rtl/mxv_lane_scheduler.sv | 152 +++++++++++++++
 tb/tb_mxv_lane_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxv_pkg.sv
// Shared types and helpers for the matrix-by-vector lane scheduler.
package mxv_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  function automatic logic [63:0] ceil_div(input logic [63:0] num, input logic [63:0] den);
    return (num / den) + (((num % den) != '0) ? 64'd1 : 64'd0);
  endfunction

  // Low bit of slice idx in a bus packed as consecutive width-bit fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mxv_lane_mac.sv
// One multiply-accumulate lane: ELEMS products summed per beat into a wrapping accumulator.
module mxv_lane_mac
  import mxv_pkg::*;
#(
  parameter int unsigned ELEM_W = 32,
  parameter int unsigned ELEMS  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    beat_en,
  input  logic                    lane_en,
  input  logic                    clear,
  input  logic [ELEMS*ELEM_W-1:0] a_lane,
  input  logic [ELEMS*ELEM_W-1:0] v_lane,
  output logic [ELEM_W-1:0]       acc
);

  logic [ELEM_W-1:0] acc_q;
  logic [ELEM_W-1:0] dot;

  // acc already includes the current beat so the group result can be captured on its final beat.
  always_comb begin
    dot = '0;
    for (int unsigned e = 0; e < ELEMS; e++) begin
      dot = dot + a_lane[slice_lo(e, ELEM_W) +: ELEM_W] * v_lane[slice_lo(e, ELEM_W) +: ELEM_W];
    end
    acc = acc_q + ((beat_en && lane_en) ? dot : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (beat_en && lane_en) begin
      acc_q <= acc;
    end
  end

endmodule

// File: rtl/mxv_lane_scheduler.sv
// Streams row groups into LANES MAC lanes and hands each group result to a 1-deep skid register.
module mxv_lane_scheduler
  import mxv_pkg::*;
#(
  parameter int unsigned ELEM_W = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned ELEMS  = 8,
  parameter int unsigned MULT_W = 3,
  parameter int unsigned ROWS_W = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ROWS_W-1:0]             total_rows,
  input  logic [LANES*MULT_W-1:0]       beats,
  input  logic [LANES*ELEMS*ELEM_W-1:0] a_data,
  input  logic [LANES*ELEMS*ELEM_W-1:0] v_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [LANES*ELEM_W-1:0]       res_data,
  output logic [LANES-1:0]              res_mask,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic                          busy,
  output logic                          finish
);

  localparam int unsigned DW = ELEMS * ELEM_W;

  state_t                  state;
  logic                    start_q;
  logic [ROWS_W-1:0]       rows_q, rows_rem, groups, grp_cnt;
  logic [MULT_W-1:0]       beat_cnt, g_len_q, g_len;
  logic [LANES*MULT_W-1:0] eff_q, eff;
  logic [LANES-1:0]        lane_real, lane_beat;
  logic [LANES*ELEM_W-1:0] acc_all;
  logic                    last_beat, fire;

  // Per-lane beat counts come straight from the port on a group's first beat so a
  // one-beat group can finish on the very beat that samples them.
  always_comb begin
    eff   = eff_q;
    g_len = g_len_q;
    if (beat_cnt == '0) begin
      g_len = MULT_W'(1);
      for (int unsigned l = 0; l < LANES; l++) begin
        eff[slice_lo(l, MULT_W) +: MULT_W] = (beats[slice_lo(l, MULT_W) +: MULT_W] == '0)
                                             ? MULT_W'(1) : beats[slice_lo(l, MULT_W) +: MULT_W];
        if (eff[slice_lo(l, MULT_W) +: MULT_W] > g_len) g_len = eff[slice_lo(l, MULT_W) +: MULT_W];
      end
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_real[l] = rows_rem > ROWS_W'(l);
      lane_beat[l] = beat_cnt < eff[slice_lo(l, MULT_W) +: MULT_W];
    end
    last_beat = (beat_cnt == g_len - MULT_W'(1));
    in_ready  = (state == RUN) && !(last_beat && res_valid && !res_ready);
    fire      = in_valid && in_ready;
  end

  assign busy = (state == LOAD) || (state == RUN) || (state == DRAIN);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mxv_lane_mac #(
      .ELEM_W(ELEM_W),
      .ELEMS (ELEMS)
    ) u_mac (
      .clk    (clk),
      .reset  (reset),
      .beat_en(fire && lane_beat[l]),
      .lane_en(lane_real[l]),
      .clear  (fire && last_beat),
      .a_lane (a_data[slice_lo(l, DW) +: DW]),
      .v_lane (v_data[slice_lo(l, DW) +: DW]),
      .acc    (acc_all[slice_lo(l, ELEM_W) +: ELEM_W])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      rows_q    <= '0;
      rows_rem  <= '0;
      groups    <= '0;
      grp_cnt   <= '0;
      beat_cnt  <= '0;
      g_len_q   <= '0;
      eff_q     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_mask  <= '0;
      finish    <= 1'b0;
    end else begin
      start_q <= start;
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !start_q) begin
            rows_q <= total_rows;
            state  <= LOAD;
          end
        end
        LOAD: begin
          groups   <= ROWS_W'(ceil_div(64'(rows_q), 64'(LANES)));
          rows_rem <= rows_q;
          grp_cnt  <= '0;
          beat_cnt <= '0;
          if (rows_q == '0) begin
            state  <= DONE;
            finish <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (fire) begin
            if (beat_cnt == '0) begin
              eff_q   <= eff;
              g_len_q <= g_len;
            end
            if (last_beat) begin
              res_valid <= 1'b1;
              res_data  <= acc_all;
              res_mask  <= lane_real;
              beat_cnt  <= '0;
              rows_rem  <= (rows_rem > ROWS_W'(LANES)) ? rows_rem - ROWS_W'(LANES) : '0;
              if (grp_cnt != groups) grp_cnt <= grp_cnt + ROWS_W'(1);
              if (grp_cnt == groups - ROWS_W'(1)) state <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt + MULT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!res_valid || res_ready) begin
            state  <= DONE;
            finish <= 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            state  <= IDLE;
            finish <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mxv_lane_scheduler.sv
// Directed scoreboard bench for mxv_lane_scheduler (LANES=4, ELEMS=8, ELEM_W=32).
module tb_mxv_lane_scheduler;

  localparam int unsigned ELEM_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned ELEMS  = 8;
  localparam int unsigned MULT_W = 3;
  localparam int unsigned ROWS_W = 32;

  typedef struct {
    logic [LANES*ELEM_W-1:0] data;
    logic [LANES-1:0]        mask;
  } exp_t;

  logic                          clk, reset, start, in_valid, in_ready;
  logic [ROWS_W-1:0]             total_rows;
  logic [LANES*MULT_W-1:0]       beats;
  logic [LANES*ELEMS*ELEM_W-1:0] a_data, v_data;
  logic [LANES*ELEM_W-1:0]       res_data;
  logic [LANES-1:0]              res_mask;
  logic                          res_valid, res_ready, busy, finish;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  mxv_lane_scheduler #(
    .ELEM_W(ELEM_W),
    .LANES (LANES),
    .ELEMS (ELEMS),
    .MULT_W(MULT_W),
    .ROWS_W(ROWS_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .total_rows(total_rows),
    .beats     (beats),
    .a_data    (a_data),
    .v_data    (v_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res_data  (res_data),
    .res_mask  (res_mask),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .finish    (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LANES*ELEM_W-1:0] pack4(input logic [31:0] d0, input logic [31:0] d1,
                                                    input logic [31:0] d2, input logic [31:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic push_exp(input logic [LANES*ELEM_W-1:0] d, input logic [LANES-1:0] m);
    exp_t x;
    x.data = d;
    x.mask = m;
    exp_q.push_back(x);
  endtask

  // Every element of lane l gets av / vv.
  task automatic set_lane(input int unsigned l, input logic [31:0] av, input logic [31:0] vv);
    for (int unsigned e = 0; e < ELEMS; e++) begin
      a_data[(l*ELEMS+e)*ELEM_W +: ELEM_W] = av;
      v_data[(l*ELEMS+e)*ELEM_W +: ELEM_W] = vv;
    end
  endtask

  task automatic set_all(input logic [31:0] av, input logic [31:0] vv);
    for (int unsigned l = 0; l < LANES; l++) set_lane(l, av, vv);
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send_beat();
    bit ok = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("beat_accept", ok, 1'b1);
  endtask

  task automatic start_job(input logic [31:0] rows, input bit hold);
    total_rows = rows;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_finish();
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (finish) seen = 1'b1;
    end
    chk("finish_seen", seen, 1'b1);
    chk("sb_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented result against the scoreboard head, including stall cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && res_valid) begin
        if (exp_q.size() == 0) begin
          chk("res_unexpected", res_valid, 1'b0);
        end else begin
          chk("res_data", res_data, exp_q[0].data);
          chk("res_mask", res_mask, exp_q[0].mask);
          if (res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    total_rows = '0; beats = '0; a_data = '0; v_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_mask", res_mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1) one full group, start held high throughout
    beats = {3'd1, 3'd1, 3'd1, 3'd1};
    set_all(32'd1, 32'd2);
    push_exp(pack4(32'd16, 32'd16, 32'd16, 32'd16), 4'hF);
    start_job(32'd4, 1'b1);
    send_beat();
    wait_finish();
    repeat (3) @(posedge clk);
    #1;
    chk("t1_finish_hold", finish, 1);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t1_finish_clear", finish, 0);
    chk("t1_idle_busy", busy, 0);
    @(posedge clk);
    #1;

    // 2) six rows: partial second group
    for (int unsigned l = 0; l < LANES; l++) set_lane(l, l + 1, 32'd2);
    push_exp(pack4(32'd16, 32'd32, 32'd48, 32'd64), 4'hF);
    push_exp(pack4(32'd16, 32'd32, 32'd0, 32'd0), 4'b0011);
    start_job(32'd6, 1'b0);
    send_beat();
    send_beat();
    wait_finish();

    // 3) uneven per-lane beat counts, lane0..3 = 3,1,2,0
    beats = {3'd0, 3'd2, 3'd1, 3'd3};
    set_all(32'd1, 32'd1);
    push_exp(pack4(32'd24, 32'd8, 32'd16, 32'd8), 4'hF);
    start_job(32'd4, 1'b0);
    send_beat();
    send_beat();
    chk("t3_no_early_result", res_valid, 0);
    send_beat();
    chk("t3_result_after_G", res_valid, 1);
    wait_finish();

    // 4) backpressure: group 2 first beat accepted, final beat held off; signed and wrapping data
    res_ready = 1'b0;
    beats = {3'd1, 3'd1, 3'd1, 3'd1};
    set_all(32'hFFFF_FFFD, 32'd5);
    push_exp(pack4(32'hFFFF_FF88, 32'hFFFF_FF88, 32'hFFFF_FF88, 32'hFFFF_FF88), 4'hF);
    push_exp(pack4(32'h0020_0010, 32'h0020_0010, 32'h0020_0010, 32'h0020_0010), 4'hF);
    start_job(32'd8, 1'b0);
    send_beat();
    beats = {3'd2, 3'd2, 3'd2, 3'd2};
    set_all(32'h0001_0001, 32'h0001_0001);
    in_valid = 1'b1;
    @(negedge clk);
    chk("t4_inrdy_g2_first", in_ready, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_inrdy_stall", in_ready, 0);
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("t4_inrdy_release", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_finish();

    // 5) zero rows: finish two cycles after start, no results
    start_job(32'd0, 1'b0);
    @(negedge clk);
    chk("t5_finish_early", finish, 0);
    chk("t5_busy_load", busy, 1);
    @(negedge clk);
    chk("t5_finish", finish, 1);
    chk("t5_busy_done", busy, 0);
    @(posedge clk);
    #1;

    // 6) reset mid-RUN with a pending result, then a clean job
    res_ready = 1'b0;
    beats = {3'd1, 3'd1, 3'd1, 3'd1};
    set_all(32'd1, 32'd1);
    push_exp(pack4(32'd8, 32'd8, 32'd8, 32'd8), 4'hF);
    start_job(32'd8, 1'b0);
    send_beat();
    in_valid = 1'b1;
    @(negedge clk);
    chk("t6_pending", res_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_res_valid", res_valid, 0);
    chk("t6_rst_res_data", res_data, 0);
    chk("t6_rst_res_mask", res_mask, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_finish", finish, 0);
    exp_q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    res_ready = 1'b1;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned e = 0; e < ELEMS; e++) begin
        a_data[(l*ELEMS+e)*ELEM_W +: ELEM_W] = e + 1;
        v_data[(l*ELEMS+e)*ELEM_W +: ELEM_W] = l + 1;
      end
    end
    push_exp(pack4(32'd36, 32'd72, 32'd108, 32'd144), 4'hF);
    start_job(32'd4, 1'b0);
    send_beat();
    wait_finish();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
